// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage core: forwarding selects, load-use/branch/mul-div stalls and flushes,
// mul/div start/done sequencing, and saturating stall/flush event counters (outputs combinational, counters +1 cycle).
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MdE,
    input  logic             MdDone,
    output logic             MdStart,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t state;
    logic      lw_stall;
    logic      md_stall;

    // M stage wins over W: it holds the younger write to the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (wr_m && (rd_m == rs))
                sel = 2'b10;
            else if (wr_w && (rd_w == rs))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
        md_stall = ((state == IDLE) && MdE) || ((state == BUSY) && !MdDone);
    end

    always_comb begin
        MdStart   = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            MdStart   = (state == IDLE) && MdE;
            if (md_stall) begin
                // E holds the mul/div; a bubble goes into M until the result is ready.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                // The D instruction is squashed, so any load-use hazard on it is moot.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            case (state)
                IDLE: if (MdE) state <= BUSY;
                BUSY: if (MdDone) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (StallF && (StallCount != {CNT_W{1'b1}}))
                StallCount <= StallCount + CNT_W'(1);
            if (FlushD && (FlushCount != {CNT_W{1'b1}}))
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule
